// File: rtl/lvdt_readout_ctrl.sv
// LVDT front-end readout sequencer. It scans the masked channels in ascending order and
// accumulates 2^NAVG_LOG2 conversions per channel into one result. Results use a valid/ready handshake.
module lvdt_readout_ctrl #(
    parameter int SETTLE_CYC = 4,
    parameter int NAVG_LOG2  = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   start,
    input  logic [3:0]             chan_mask,
    output logic [1:0]             lvdt_a,
    output logic                   lvdt_re,
    output logic                   lvdt_clk,
    input  logic [2:0]             lvdt_y,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [1:0]             res_chan,
    output logic [2+NAVG_LOG2:0]   res_data,
    output logic                   busy
);

    localparam int AW = 3 + NAVG_LOG2;
    localparam int NW = NAVG_LOG2 + 1;
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [NW-1:0] NSAMP_LAST  = NW'((1 << NAVG_LOG2) - 1);
    localparam logic [NW-1:0] NSAMP_ONE   = NW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        ENABLE = 3'd2,
        SAMPLE = 3'd3,
        CAPT   = 3'd4,
        OUTPUT = 3'd5
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      y_meta, y_sync;
    logic [3:0]      mask_q;
    logic [1:0]      chan_q;
    logic [AW-1:0]   acc_q;
    logic [7:0]      settle_q;
    logic [NW-1:0]   nsamp_q;

    logic [2:0]      first_sel, next_sel;
    logic            load_first, load_next, capt_done;

    // Returns {found, channel}: the lowest set mask bit at or above 'from'.
    function automatic logic [2:0] pick_chan(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign first_sel = pick_chan(chan_mask, 3'd0);
    assign next_sel  = pick_chan(mask_q, {1'b0, chan_q} + 3'd1);

    always_comb begin
        state_nx   = state;
        load_first = 1'b0;
        load_next  = 1'b0;
        capt_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start && (chan_mask != 4'b0000)) begin
                    state_nx   = SELECT;
                    load_first = 1'b1;
                end
            end
            SELECT: begin
                if (settle_q == SETTLE_LAST) state_nx = ENABLE;
            end
            ENABLE: begin
                if (settle_q == SETTLE_LAST) state_nx = SAMPLE;
            end
            SAMPLE: begin
                state_nx = CAPT;
            end
            CAPT: begin
                if (settle_q == 8'd1) begin
                    capt_done = 1'b1;
                    state_nx  = (nsamp_q == NSAMP_LAST) ? OUTPUT : SAMPLE;
                end
            end
            OUTPUT: begin
                if (res_ready) begin
                    if (next_sel[2]) begin
                        state_nx  = SELECT;
                        load_next = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        lvdt_re   = (state == ENABLE) || (state == SAMPLE) || (state == CAPT);
        lvdt_clk  = (state == SAMPLE);
        res_valid = (state == OUTPUT);
        lvdt_a    = busy ? chan_q : 2'd0;
        res_chan  = res_valid ? chan_q : 2'd0;
        res_data  = res_valid ? acc_q : '0;
    end

    // settle_q times every state; it restarts whenever the state changes.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state    <= IDLE;
            y_meta   <= '0;
            y_sync   <= '0;
            mask_q   <= '0;
            chan_q   <= '0;
            acc_q    <= '0;
            settle_q <= '0;
            nsamp_q  <= '0;
        end else begin
            state    <= state_nx;
            y_meta   <= lvdt_y;
            y_sync   <= y_meta;
            settle_q <= (state_nx != state) ? 8'd0 : settle_q + 8'd1;
            if (load_first) begin
                mask_q  <= chan_mask;
                chan_q  <= first_sel[1:0];
                acc_q   <= '0;
                nsamp_q <= '0;
            end
            if (capt_done) begin
                acc_q   <= acc_q + AW'(y_sync);
                nsamp_q <= nsamp_q + NSAMP_ONE;
            end
            if (load_next) begin
                chan_q  <= next_sel[1:0];
                acc_q   <= '0;
                nsamp_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lvdt_readout_ctrl.sv
// Bench for lvdt_readout_ctrl: scoreboard of expected {chan,data} results from a per-scan model,
// plus a second instance with the short configuration (NAVG_LOG2=0, SETTLE_CYC=1).
module tb_lvdt_readout_ctrl;

    localparam int SETTLE = 4;
    localparam int NLOG   = 2;
    localparam int DW     = 3 + NLOG;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, res_ready, lvdt_re, lvdt_clk, res_valid, busy;
    logic [3:0]    chan_mask;
    logic [1:0]    lvdt_a, res_chan;
    logic [2:0]    lvdt_y;
    logic [DW-1:0] res_data;

    logic          start1, ready1, re1, clk1, valid1, busy1;
    logic [3:0]    mask1;
    logic [1:0]    a1, chan1;
    logic [2:0]    y1, data1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW+1:0] exp_q[$];
    int ready_mode = 0;
    int stall      = 0;
    int clk_pulses = 0;
    logic          prev_valid = 1'b0;
    logic          prev_hs    = 1'b0;
    logic [DW+1:0] prev_pair  = '0;

    lvdt_readout_ctrl #(.SETTLE_CYC(SETTLE), .NAVG_LOG2(NLOG)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start), .chan_mask(chan_mask),
        .lvdt_a(lvdt_a), .lvdt_re(lvdt_re), .lvdt_clk(lvdt_clk), .lvdt_y(lvdt_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
        .res_data(res_data), .busy(busy)
    );

    lvdt_readout_ctrl #(.SETTLE_CYC(1), .NAVG_LOG2(0)) dut1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start1), .chan_mask(mask1),
        .lvdt_a(a1), .lvdt_re(re1), .lvdt_clk(clk1), .lvdt_y(y1),
        .res_valid(valid1), .res_ready(ready1), .res_chan(chan1),
        .res_data(data1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Consumer: 0 = always ready, 1 = random, 2 = hold off 10 cycles per result.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: res_ready = 1'b1;
            1: res_ready = 1'($urandom_range(0, 1));
            default: begin
                if (!res_valid) begin
                    res_ready = 1'b0;
                    stall = 0;
                end else if (stall < 10) begin
                    res_ready = 1'b0;
                    stall++;
                end else begin
                    res_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor: pops the scoreboard on each handshake and checks output invariants.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (lvdt_clk) begin
                clk_pulses++;
                check("re_high_during_strobe", 32'(lvdt_re), 32'd1);
            end
            if (res_valid) begin
                check("re_low_in_output", 32'(lvdt_re), 32'd0);
                check("a_matches_res_chan", 32'(lvdt_a), 32'(res_chan));
                if (prev_valid && !prev_hs)
                    check("stable_while_stalled", 32'({res_chan, res_data}), 32'(prev_pair));
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got chan %0d data %0d, none expected",
                                 res_chan, res_data);
                    end else begin
                        check("result_chan_data", 32'({res_chan, res_data}), 32'(exp_q.pop_front()));
                    end
                    check("strobes_per_result", 32'(clk_pulses), 32'(1 << NLOG));
                    clk_pulses = 0;
                end
            end
            prev_valid = res_valid;
            prev_hs    = res_valid && res_ready;
            prev_pair  = {res_chan, res_data};
        end
    end

    // One scan: model pushes one result per set mask bit, ascending, each y * 2^NLOG.
    task automatic scan(input logic [3:0] m, input logic [2:0] y, input int mode, input bit extra_start);
        int n;
        ready_mode = mode;
        lvdt_y = y;
        repeat (3) @(negedge clk);
        if (m != 4'b0000)
            for (int i = 0; i < 4; i++)
                if (m[i]) exp_q.push_back({2'(i), DW'(int'(y) * (1 << NLOG))});
        chan_mask = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chan_mask = 4'($urandom);
        if (m == 4'b0000) begin
            @(negedge clk);
            check("zero_mask_ignored", 32'(busy), 32'd0);
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (extra_start && n == 5) begin
                start = 1'b1;
                chan_mask = 4'hf;
            end else begin
                start = 1'b0;
            end
        end while (!res_valid && n < 2000);
        start = 1'b0;
        check("first_valid_cycle", 32'(n), 32'(2 * SETTLE + 3 * (1 << NLOG) + 1));
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("scan_finished", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; chan_mask = 4'h0; lvdt_y = 3'd0; res_ready = 1'b1;
        start1 = 1'b0; mask1 = 4'h0; y1 = 3'd0; ready1 = 1'b1;
        repeat (3) @(negedge clk);
        check("outputs_in_reset",
              32'({lvdt_a, lvdt_re, lvdt_clk, res_valid, res_chan, res_data, busy}), 32'd0);
        start = 1'b1; chan_mask = 4'hf;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("start_in_reset_ignored",
              32'({lvdt_a, lvdt_re, lvdt_clk, res_valid, res_chan, res_data, busy}), 32'd0);

        scan(4'b0100, 3'd5, 0, 1'b0);
        scan(4'b1011, 3'd7, 2, 1'b0);
        scan(4'b0000, 3'd3, 0, 1'b0);
        scan(4'b0110, 3'd2, 1, 1'b1);

        // Abort a scan during CAPT, then confirm a clean restart.
        ready_mode = 0;
        lvdt_y = 3'd6;
        repeat (3) @(negedge clk);
        chan_mask = 4'b0010; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lvdt_clk && n < 200);
        check("strobe_seen_before_abort", 32'(lvdt_clk), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("outputs_after_abort",
              32'({lvdt_a, lvdt_re, lvdt_clk, res_valid, res_chan, res_data, busy}), 32'd0);
        rst_n = 1'b1;
        clk_pulses = 0;
        exp_q.delete();
        scan(4'b0010, 3'd1, 0, 1'b0);

        for (int k = 0; k < 8; k++)
            scan(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        // Short configuration: one conversion per channel.
        y1 = 3'd3;
        repeat (3) @(negedge clk);
        mask1 = 4'b0001; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        clk_pulses = 0;
        do begin
            @(negedge clk);
            n++;
            if (clk1) clk_pulses++;
        end while (!valid1 && n < 200);
        check("short_first_valid_cycle", 32'(n), 32'd6);
        check("short_res_data", 32'(data1), 32'd3);
        check("short_res_chan", 32'(chan1), 32'd0);
        check("short_strobe_count", 32'(clk_pulses), 32'd1);
        @(negedge clk);
        check("short_idle_after_handshake", 32'(busy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvdt_readout_ctrl.md
LVDT_READOUT_CTRL -- requirements
Module: lvdt_readout_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE_CYC, default 4: cycles spent in each of SELECT and ENABLE (legal 1..255).
REQ-002 SHALL provide parameter NAVG_LOG2, default 2: log2 of the number of samples accumulated per channel (legal 0..4).
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1 bit: synchronous reset, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to scan the channels in chan_mask.
REQ-006 SHALL have port chan_mask, input, 4 bits: channels to scan; bit n enables channel n.
REQ-007 SHALL have port lvdt_a, output, 2 bits: channel select to the LVDT front end ({a2,a1}).
REQ-008 SHALL have port lvdt_re, output, 1 bit: front-end read enable.
REQ-009 SHALL have port lvdt_clk, output, 1 bit: conversion strobe to the front end.
REQ-010 SHALL have port lvdt_y, input, 3 bits: asynchronous front-end code ({y2,y1,y0}).
REQ-011 SHALL have port res_valid, output, 1 bit: result available.
REQ-012 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port res_chan, output, 2 bits: channel of the current result.
REQ-014 SHALL have port res_data, output, 3+NAVG_LOG2 bits: sum of the samples.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL synchronize lvdt_y through two flops before any use.
REQ-017 SHALL use these states: IDLE, SELECT, ENABLE, SAMPLE, CAPT, OUTPUT.
REQ-018 IDLE: on start=1 with chan_mask!=0, SHALL latch chan_mask, go to SELECT on the lowest set channel, and clear the accumulator.
REQ-019 A start with chan_mask=0, or any start while busy=1, SHALL be ignored.
REQ-020 SELECT: lvdt_a=channel, lvdt_re=0, for SETTLE_CYC cycles, then go to ENABLE.
REQ-021 ENABLE: lvdt_re=1, for SETTLE_CYC cycles, then go to SAMPLE.
REQ-022 lvdt_re SHALL stay 1 through ENABLE, SAMPLE and CAPT, and SHALL be 0 in IDLE, SELECT and OUTPUT.
REQ-023 lvdt_a SHALL hold the channel value from SELECT until the end of OUTPUT.
REQ-024 SAMPLE: lvdt_clk=1 for exactly one cycle; lvdt_clk SHALL be 0 in all other states.
REQ-025 CAPT: two cycles; on the last edge SHALL add the synchronized lvdt_y, zero-extended, to the accumulator.
REQ-026 SAMPLE/CAPT SHALL repeat until 2^NAVG_LOG2 samples are taken, then go to OUTPUT.
REQ-027 The accumulator SHALL be 3+NAVG_LOG2 bits wide and SHALL never wrap (maximum 7*2^NAVG_LOG2).
REQ-028 OUTPUT: res_valid=1; res_chan and res_data SHALL stay stable until the handshake.
REQ-029 The handshake SHALL complete on the edge where res_valid=1 and res_ready=1.
REQ-030 On handshake, if a higher latched channel remains, SHALL go to SELECT for the next set channel in ascending order and clear the accumulator; otherwise go to IDLE.
REQ-031 res_ready while res_valid=0 SHALL have no effect.
REQ-032 With defaults, res_valid SHALL first be 1 in cycle 21, counting the edge that samples start as cycle 0.
REQ-033 Changes to chan_mask after start is accepted SHALL not affect the scan in progress.

Reset
REQ-034 When wb_rst_ni=0 at an edge, from any state, SHALL enter IDLE and clear the accumulator, latched mask, channel register and synchronizer.
REQ-035 During and after reset SHALL drive lvdt_a=0, lvdt_re=0, lvdt_clk=0, res_valid=0, res_chan=0, res_data=0, busy=0.
REQ-036 A start sampled in the same cycle as wb_rst_ni=0 SHALL be ignored.

Verification
REQ-037 Defaults, chan_mask=4'b0100, lvdt_y=3'd5 constant, start pulse, res_ready=1 -> lvdt_a=2; exactly 4 lvdt_clk pulses; res_valid in cycle 21 with res_chan=2, res_data=20; busy=0 next cycle.
REQ-038 chan_mask=4'b1011, lvdt_y=7, res_ready held 0 for 10 cycles per result -> results for channels 0, 1, 3 in order, each res_data=28; outputs stable while stalled; lvdt_re=0 during OUTPUT.
REQ-039 start with chan_mask=0, then a second start while busy -> no state change from the first; the second is ignored and the scan completes normally.
REQ-040 wb_rst_ni=0 for one cycle mid-CAPT of a scan -> all outputs at reset values on the next cycle; a new start gives a fresh result with no residue from the aborted accumulation.
REQ-041 NAVG_LOG2=0, SETTLE_CYC=1, lvdt_y=3 -> exactly one lvdt_clk pulse; res_data=3 (3 bits wide); res_valid in cycle 6.
